// File: rtl/npc_gen_pkg.sv
// ----------------------------------------------------------------------------
// npc_gen_pkg
//   Shared encodings for the next-PC generator.
//   - npc_op_e    : next-PC selection code of the instruction at pc
//   - npc_state_e : fetch FSM state codes
//   - PC_PLUS_4   : sequential increment, kept for older users
// ----------------------------------------------------------------------------
package npc_gen_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'b00,
    NPC_BR   = 2'b01,
    NPC_JAL  = 2'b10,
    NPC_JALR = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    NPCS_BOOT = 2'b00,
    NPCS_RUN  = 2'b01,
    NPCS_HALT = 2'b10
  } npc_state_e;

  localparam int unsigned PC_PLUS_4 = 4;

endpackage : npc_gen_pkg

// File: rtl/npc_gen_target.sv
// ----------------------------------------------------------------------------
// npc_target
//   Combinational target adder for the next-PC generator.
//   Ports:
//     pc, imm, rs1  in   XLEN  current PC, sign-extended immediate, JALR base
//     npc_op        in   2     selection code (npc_op_e)
//     br_taken      in   1     branch condition, used only for NPC_BR
//     target        out  XLEN  selected non-redirect target (JALR / JAL / BR / pc+ILEN_B)
//     misaligned    out  1     a jump/taken-branch target has bits[1:0] != 0
//   All sums are XLEN bits with the carry dropped.
// ----------------------------------------------------------------------------
module npc_target
  import npc_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ILEN_B = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [1:0]      npc_op,
  input  logic            br_taken,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic            is_jump;
  logic [XLEN-1:0] jalr_sum;

  assign jalr_sum = rs1 + imm;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    target  = pc + XLEN'(ILEN_B);
    is_jump = 1'b0;
    case (npc_op)
      NPC_JALR: begin
        target    = jalr_sum;
        target[0] = 1'b0;
        is_jump   = 1'b1;
      end
      NPC_JAL: begin
        target  = pc + imm;
        is_jump = 1'b1;
      end
      NPC_BR: begin
        if (br_taken) begin
          target  = pc + imm;
          is_jump = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequential fall-through is always aligned; only jump targets are checked.
  assign misaligned = is_jump && (target[1:0] != 2'b00);

endmodule : npc_target

// File: rtl/npc_gen.sv
// ----------------------------------------------------------------------------
// npc_gen
//   Next-PC generator: owns the architectural PC, selects branch/JAL/JALR
//   targets, honours stall, external redirect and halt.
//   Optional feature macro: NPC_MISALIGN_EN (misaligned jump targets trap to
//   TRAP_VEC and are reported on misalign/bad_addr). Without it misaligned
//   targets are used as-is and misalign/bad_addr are tied to 0.
//   Ports:
//     clk, rst_n   in   1     clock, asynchronous active-low reset
//     npc_op       in   2     selection code for the instruction at pc
//     br_taken     in   1     branch condition
//     imm, rs1     in   XLEN  immediate, JALR base
//     stall        in   1     hold pc this cycle
//     redir_vld    in   1     external redirect request
//     redir_pc     in   XLEN  redirect target
//     halt_req     in   1     stop fetching after the current instruction
//     pc           out  XLEN  current PC (registered)
//     pc4          out  XLEN  pc + ILEN_B
//     npc          out  XLEN  value pc takes at the next advancing edge
//     pc_vld       out  1     pc holds a fetchable address (registered)
//     misalign     out  1     one-cycle trap pulse
//     bad_addr     out  XLEN  offending target of the last trap
// ----------------------------------------------------------------------------
module npc_gen
  import npc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0004),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int              ILEN_B    = PC_PLUS_4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      npc_op,
  input  logic            br_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            stall,
  input  logic            redir_vld,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] npc,
  output logic            pc_vld,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);

  npc_state_e      state, state_nxt;
  logic            pc_load;
  logic [XLEN-1:0] target;
  logic            tgt_misaligned;

  npc_target #(
    .XLEN   (XLEN),
    .ILEN_B (ILEN_B)
  ) u_target (
    .pc         (pc),
    .imm        (imm),
    .rs1        (rs1),
    .npc_op     (npc_op),
    .br_taken   (br_taken),
    .target     (target),
    .misaligned (tgt_misaligned)
  );

  assign pc4 = pc + XLEN'(ILEN_B);

  // Redirect outranks everything, including a misaligned jump in the same cycle.
`ifdef NPC_MISALIGN_EN
  logic trap;

  assign npc  = redir_vld      ? redir_pc :
                tgt_misaligned ? TRAP_VEC : target;
  // A trap is taken only on an edge that actually advances the PC.
  assign trap = tgt_misaligned & ~redir_vld & ~stall & (state == NPCS_RUN);
`else
  logic unused_misaligned;

  assign npc               = redir_vld ? redir_pc : target;
  assign unused_misaligned = tgt_misaligned;
`endif

  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    case (state)
      // One bubble cycle; a redirect here still lands on its target.
      NPCS_BOOT: begin
        state_nxt = NPCS_RUN;
        pc_load   = redir_vld;
      end
      // A redirect applies even while stalled and cancels a pending halt.
      NPCS_RUN: begin
        if (redir_vld) begin
          pc_load = 1'b1;
        end else if (!stall) begin
          pc_load = 1'b1;
          if (halt_req) state_nxt = NPCS_HALT;
        end
      end
      NPCS_HALT: begin
        if (redir_vld) begin
          pc_load   = 1'b1;
          state_nxt = NPCS_RUN;
        end
      end
      default: state_nxt = NPCS_BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= NPCS_BOOT;
      pc     <= RESET_VEC;
      pc_vld <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_vld <= (state_nxt == NPCS_RUN);
      if (pc_load) pc <= npc;
    end
  end

`ifdef NPC_MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
      bad_addr <= '0;
    end else begin
      misalign <= trap;
      if (trap) bad_addr <= target;
    end
  end
`else
  assign misalign = 1'b0;
  assign bad_addr = '0;
`endif

endmodule : npc_gen

// File: tb/tb_npc_gen.sv
// ----------------------------------------------------------------------------
// tb_npc_gen
//   Directed self-checking bench for npc_gen. Inputs change 1 time unit after
//   a rising edge; outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_npc_gen;
  import npc_gen_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      npc_op;
  logic            br_taken;
  logic [XLEN-1:0] imm, rs1;
  logic            stall, redir_vld, halt_req;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc, pc4, npc, bad_addr;
  logic            pc_vld, misalign;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  npc_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .npc_op    (npc_op),
    .br_taken  (br_taken),
    .imm       (imm),
    .rs1       (rs1),
    .stall     (stall),
    .redir_vld (redir_vld),
    .redir_pc  (redir_pc),
    .halt_req  (halt_req),
    .pc        (pc),
    .pc4       (pc4),
    .npc       (npc),
    .pc_vld    (pc_vld),
    .misalign  (misalign),
    .bad_addr  (bad_addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Positions the PC through the redirect path, leaving all controls idle.
  task automatic set_pc(input logic [XLEN-1:0] addr);
    redir_vld = 1'b1;
    redir_pc  = addr;
    step();
    redir_vld = 1'b0;
    redir_pc  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; npc_op = NPC_SEQ; br_taken = 1'b0; imm = '0; rs1 = '0;
    stall = 1'b0; redir_vld = 1'b0; redir_pc = '0; halt_req = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h4); end
    n_cmp++; if (pc_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got=%b exp=0", pc_vld); end
    n_cmp++; if (misalign !== 1'b0 || bad_addr !== '0) begin n_err++; $display("FAIL reset_trap got=%b/%h exp=0/0", misalign, bad_addr); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (pc !== 32'h4 || pc_vld !== 1'b0) begin n_err++; $display("FAIL boot_c0 got=%h/%b exp=00000004/0", pc, pc_vld); end
    n_cmp++; if (pc4 !== 32'h8) begin n_err++; $display("FAIL boot_pc4 got=%h exp=00000008", pc4); end
    step();
    n_cmp++; if (pc !== 32'h4 || pc_vld !== 1'b1) begin n_err++; $display("FAIL boot_c1 got=%h/%b exp=00000004/1", pc, pc_vld); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (pc !== 32'h8 + 32'(4 * i)) begin n_err++; $display("FAIL seq%0d got=%h exp=%h", i, pc, 32'h8 + 32'(4 * i)); end
    end
  endtask

  task automatic test_ops();
    set_pc(32'h20);
    npc_op = NPC_JAL; imm = 32'h40;
    #1;
    n_cmp++; if (npc !== 32'h60) begin n_err++; $display("FAIL jal_npc got=%h exp=00000060", npc); end
    step();
    n_cmp++; if (pc !== 32'h60) begin n_err++; $display("FAIL jal got=%h exp=00000060", pc); end
    npc_op = NPC_SEQ; set_pc(32'h20);
    npc_op = NPC_BR; br_taken = 1'b1; step();
    n_cmp++; if (pc !== 32'h60) begin n_err++; $display("FAIL br_taken got=%h exp=00000060", pc); end
    npc_op = NPC_SEQ; set_pc(32'h20);
    npc_op = NPC_BR; br_taken = 1'b0; step();
    n_cmp++; if (pc !== 32'h24) begin n_err++; $display("FAIL br_not got=%h exp=00000024", pc); end
    npc_op = NPC_SEQ; set_pc(32'h20);
    npc_op = NPC_JALR; rs1 = 32'h101; imm = 32'h10; step();
    n_cmp++; if (pc !== 32'h110) begin n_err++; $display("FAIL jalr got=%h exp=00000110", pc); end
    npc_op = NPC_SEQ; imm = '0; rs1 = '0; br_taken = 1'b0;
  endtask

  task automatic test_stall();
    set_pc(32'h30);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (pc !== 32'h30 || pc_vld !== 1'b1) begin n_err++; $display("FAIL stall%0d got=%h/%b exp=00000030/1", i, pc, pc_vld); end
    end
    redir_vld = 1'b1; redir_pc = 32'h200; step();
    n_cmp++; if (pc !== 32'h200) begin n_err++; $display("FAIL stall_redir got=%h exp=00000200", pc); end
    redir_vld = 1'b0; stall = 1'b0;
  endtask

  task automatic test_halt();
    set_pc(32'h40);
    halt_req = 1'b1; step();
    n_cmp++; if (pc !== 32'h44 || pc_vld !== 1'b0) begin n_err++; $display("FAIL halt got=%h/%b exp=00000044/0", pc, pc_vld); end
    npc_op = NPC_JAL; imm = 32'h8;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (pc !== 32'h44 || pc_vld !== 1'b0) begin n_err++; $display("FAIL halt_hold%0d got=%h/%b exp=00000044/0", i, pc, pc_vld); end
    end
    npc_op = NPC_SEQ; imm = '0; halt_req = 1'b0;
    redir_vld = 1'b1; redir_pc = 32'h80; step();
    n_cmp++; if (pc !== 32'h80 || pc_vld !== 1'b1) begin n_err++; $display("FAIL halt_exit got=%h/%b exp=00000080/1", pc, pc_vld); end
    // Redirect and halt together: redirect wins, halt dropped.
    redir_pc = 32'h90; halt_req = 1'b1; step();
    redir_vld = 1'b0; halt_req = 1'b0;
    n_cmp++; if (pc !== 32'h90 || pc_vld !== 1'b1) begin n_err++; $display("FAIL redir_halt got=%h/%b exp=00000090/1", pc, pc_vld); end
    step();
    n_cmp++; if (pc !== 32'h94 || pc_vld !== 1'b1) begin n_err++; $display("FAIL redir_halt_run got=%h/%b exp=00000094/1", pc, pc_vld); end
  endtask

  task automatic test_wrap();
    set_pc(32'hFFFF_FFFC);
    n_cmp++; if (pc4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4 got=%h exp=00000000", pc4); end
    step();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_seq got=%h exp=00000000", pc); end
    set_pc(32'h4);
    npc_op = NPC_JAL; imm = 32'hFFFF_FFF8; step();
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_jal got=%h exp=fffffffc", pc); end
    npc_op = NPC_SEQ; imm = '0;
  endtask

  task automatic test_misalign();
    // A stalled cycle never traps.
    set_pc(32'h10);
    npc_op = NPC_JAL; imm = 32'h6; stall = 1'b1; step();
    n_cmp++; if (pc !== 32'h10 || misalign !== 1'b0) begin n_err++; $display("FAIL mis_stall got=%h/%b exp=00000010/0", pc, misalign); end
    stall = 1'b0; step();
`ifdef NPC_MISALIGN_EN
    n_cmp++; if (pc !== 32'h100 || misalign !== 1'b1) begin n_err++; $display("FAIL mis_trap got=%h/%b exp=00000100/1", pc, misalign); end
    n_cmp++; if (bad_addr !== 32'h16) begin n_err++; $display("FAIL mis_bad got=%h exp=00000016", bad_addr); end
    npc_op = NPC_SEQ; imm = '0; step();
    n_cmp++; if (pc !== 32'h104 || misalign !== 1'b0 || bad_addr !== 32'h16) begin n_err++; $display("FAIL mis_after got=%h/%b/%h exp=00000104/0/00000016", pc, misalign, bad_addr); end
`else
    n_cmp++; if (pc !== 32'h16 || misalign !== 1'b0) begin n_err++; $display("FAIL mis_off got=%h/%b exp=00000016/0", pc, misalign); end
    n_cmp++; if (bad_addr !== '0) begin n_err++; $display("FAIL mis_off_bad got=%h exp=00000000", bad_addr); end
`endif
    npc_op = NPC_SEQ; imm = '0;
  endtask

  task automatic test_reset_mid();
    set_pc(32'h500);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (pc !== 32'h4 || pc_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst got=%h/%b exp=00000004/0", pc, pc_vld); end
    n_cmp++; if (misalign !== 1'b0 || bad_addr !== '0) begin n_err++; $display("FAIL mid_rst_trap got=%b/%h exp=0/0", misalign, bad_addr); end
    step();
    rst_n = 1'b1;
    // Redirect during the boot bubble lands directly on its target.
    redir_vld = 1'b1; redir_pc = 32'h300; step();
    redir_vld = 1'b0;
    n_cmp++; if (pc !== 32'h300 || pc_vld !== 1'b1) begin n_err++; $display("FAIL boot_redir got=%h/%b exp=00000300/1", pc, pc_vld); end
    step();
    n_cmp++; if (pc !== 32'h304) begin n_err++; $display("FAIL boot_redir_seq got=%h exp=00000304", pc); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_stall();
    test_halt();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_npc_gen
